// File: rtl/usbh_tx_seq.sv
// rtl/usbh_tx_seq.sv - USB host TX sequencer: streams a FIFO packet of known length to the SIE
// Handles prime timeout, mid-packet underrun and abort, with a one-cycle FIFO flush on error.
module usbh_tx_seq #(
    parameter int LEN_W         = 16,
    parameter int PRIME_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_last_o,
    input  logic             tx_accept_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o,
    output logic [LEN_W-1:0] remaining_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(PRIME_TIMEOUT - 1);
    localparam logic [7:0] TMO_SAT  = 8'(PRIME_TIMEOUT);

    logic [1:0]       state;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       prime_cnt;
    logic             underrun;
    logic             done;
    logic             offer;
    logic             pop;

    assign offer = (state == ST_SEND) && !fifo_empty_i;
    // Abort outranks a coincident accept so the aborted byte stays in the FIFO until the flush.
    assign pop   = offer && tx_accept_i && !abort_i;

    assign tx_valid_o   = offer;
    assign tx_data_o    = offer ? fifo_data_i : 8'h00;
    assign tx_last_o    = offer && (remaining == LEN_W'(1));
    assign fifo_pop_o   = pop;
    assign fifo_flush_o = (state == ST_FLUSH);
    assign busy_o       = (state != ST_IDLE);
    assign done_o       = done;
    assign underrun_o   = underrun;
    assign remaining_o  = remaining;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            remaining <= '0;
            prime_cnt <= '0;
            underrun  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        underrun <= 1'b0;
                        if (len_i == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= len_i;
                            prime_cnt <= '0;
                            state     <= ST_PRIME;
                        end
                    end
                end
                ST_PRIME: begin
                    if (abort_i) begin
                        state <= ST_FLUSH;
                    end else if (!fifo_empty_i) begin
                        state <= ST_SEND;
                    end else if (prime_cnt >= TMO_LAST) begin
                        prime_cnt <= TMO_SAT;
                        underrun  <= 1'b1;
                        state     <= ST_FLUSH;
                    end else begin
                        prime_cnt <= prime_cnt + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (abort_i) begin
                        state <= ST_FLUSH;
                    end else if (fifo_empty_i) begin
                        // The SIE cannot stall mid-packet, so a gap in the stream is fatal.
                        underrun <= 1'b1;
                        state    <= ST_FLUSH;
                    end else if (pop) begin
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_W'(1);
                        end
                        if (remaining == LEN_W'(1)) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    remaining <= '0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbh_tx_seq.sv
// tb/tb_usbh_tx_seq.sv - directed bench for usbh_tx_seq with FIFO model and byte scoreboard
module tb_usbh_tx_seq;

    localparam int LEN_W = 16;
    localparam int TMO   = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_accept;
    logic             busy;
    logic             done;
    logic             underrun;
    logic [LEN_W-1:0] remaining;

    logic [7:0] fq[$];
    exp_t       exp_q[$];
    exp_t       e;
    logic       pend_pop;
    logic       pend_flush;
    int         total;
    int         bad;
    int         pop_cnt;
    int         done_cnt;
    int         flush_cnt;
    int         n;

    usbh_tx_seq #(.LEN_W(LEN_W), .PRIME_TIMEOUT(TMO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .start_i      (start),
        .len_i        (len),
        .abort_i      (abort),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (fifo_pop),
        .fifo_flush_o (fifo_flush),
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .tx_last_o    (tx_last),
        .tx_accept_i  (tx_accept),
        .busy_o       (busy),
        .done_o       (done),
        .underrun_o   (underrun),
        .remaining_o  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 8'hEE : fq[0];
    endfunction

    task automatic load(input logic [7:0] base, input int cnt);
        for (int i = 0; i < cnt; i++) fq.push_back(base + 8'(i));
        refresh();
    endtask

    task automatic expect_bytes(input logic [7:0] base, input int cnt, input int plen);
        for (int i = 0; i < cnt; i++) begin
            exp_t x;
            x.data = base + 8'(i);
            x.last = (i == plen - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        pop_cnt   = 0;
        done_cnt  = 0;
        flush_cnt = 0;
    endtask

    // Output monitor: samples mid-cycle, scoreboards every popped byte.
    always @(negedge clk) begin
        pend_pop   = fifo_pop;
        pend_flush = fifo_flush;
        if (done) done_cnt++;
        if (fifo_flush) flush_cnt++;
        if (fifo_pop) begin
            pop_cnt++;
            chk("pop_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_data", tx_data, e.data);
                chk("tx_last", tx_last, e.last);
            end
        end
    end

    // FWFT FIFO model: head advances just after the edge that accepted it.
    always begin
        @(posedge clk);
        #1;
        if (pend_flush) fq.delete();
        else if (pend_pop && fq.size() > 0) void'(fq.pop_front());
        pend_pop   = 1'b0;
        pend_flush = 1'b0;
        refresh();
    end

    initial begin
        total = 0; bad = 0;
        clear_counts();
        pend_pop = 0; pend_flush = 0;
        rst_n = 0; start = 0; len = '0; abort = 0; tx_accept = 0;
        refresh();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_flush", fifo_flush, 0);
        rst_n = 1;
        tick();

        // Normal 8-byte packet, accept held high
        clear_counts();
        load(8'h01, 8);
        expect_bytes(8'h01, 8, 8);
        tx_accept = 1; start = 1; len = 16'd8;
        tick();
        start = 0;
        chk("n_prime_busy", busy, 1);
        chk("n_prime_rem", remaining, 8);
        chk("n_prime_valid", tx_valid, 0);
        tick();
        chk("n_first_valid", tx_valid, 1);
        chk("n_first_data", tx_data, 8'h01);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("n_done_seen", done, 1);
        chk("n_cycles", n, 8);
        chk("n_busy_at_done", busy, 0);
        chk("n_pops", pop_cnt, 8);
        chk("n_fifo_empty", fq.size(), 0);
        chk("n_sb_empty", exp_q.size(), 0);
        chk("n_underrun", underrun, 0);
        tick();
        chk("n_done_pulse", done, 0);
        chk("n_done_cnt", done_cnt, 1);

        // Backpressure: every byte held one cycle before acceptance
        clear_counts();
        tx_accept = 0;
        load(8'hA0, 4);
        expect_bytes(8'hA0, 4, 4);
        start = 1; len = 16'd4;
        tick();
        start = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rem", remaining, 4 - i);
            chk("bp_valid", tx_valid, 1);
            chk("bp_data", tx_data, 8'hA0 + i);
            chk("bp_last", tx_last, i == 3);
            tick();
            chk("bp_hold_data", tx_data, 8'hA0 + i);
            chk("bp_hold_rem", remaining, 4 - i);
            tx_accept = 1;
            tick();
            tx_accept = 0;
        end
        chk("bp_rem_end", remaining, 0);
        chk("bp_done", done, 1);
        chk("bp_pops", pop_cnt, 4);

        // Zero length
        tick();
        clear_counts();
        start = 1; len = 16'd0;
        tick();
        start = 0;
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        tick();
        chk("z_done_pulse", done, 0);
        chk("z_busy2", busy, 0);
        chk("z_pops", pop_cnt, 0);

        // Prime timeout with an empty FIFO
        clear_counts();
        start = 1; len = 16'd3;
        tick();
        start = 0;
        n = 0;
        while (!underrun && n < 30) begin tick(); n++; end
        chk("pt_underrun", underrun, 1);
        chk("pt_cycles", n, TMO);
        chk("pt_flush", fifo_flush, 1);
        tick();
        chk("pt_flush_pulse", fifo_flush, 0);
        chk("pt_busy", busy, 0);
        chk("pt_rem", remaining, 0);
        chk("pt_sticky", underrun, 1);
        chk("pt_flush_cnt", flush_cnt, 1);
        chk("pt_done_cnt", done_cnt, 0);

        // Mid-packet underrun, then a fresh start clears the flag
        clear_counts();
        load(8'h55, 2);
        expect_bytes(8'h55, 2, 5);
        tx_accept = 1; start = 1; len = 16'd5;
        tick();
        start = 0;
        chk("mu_cleared", underrun, 0);
        n = 0;
        while (!underrun && n < 20) begin tick(); n++; end
        chk("mu_underrun", underrun, 1);
        chk("mu_cycles", n, 4);
        chk("mu_flush", fifo_flush, 1);
        chk("mu_rem", remaining, 3);
        chk("mu_pops", pop_cnt, 2);
        tick();
        chk("mu_rem_end", remaining, 0);
        chk("mu_done_cnt", done_cnt, 0);
        load(8'h77, 1);
        expect_bytes(8'h77, 1, 1);
        start = 1; len = 16'd1;
        tick();
        start = 0;
        chk("mu_restart_clear", underrun, 0);
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        chk("mu_restart_done", done, 1);
        chk("mu_restart_cycles", n, 2);
        chk("mu_sb_empty", exp_q.size(), 0);

        // Abort coincident with accept on byte 3 of 6
        tick();
        clear_counts();
        load(8'h10, 6);
        expect_bytes(8'h10, 2, 6);
        tx_accept = 1; start = 1; len = 16'd6;
        tick();
        start = 0;
        repeat (3) tick();
        chk("ab_data", tx_data, 8'h12);
        abort = 1;
        #1;
        chk("ab_no_pop", fifo_pop, 0);
        chk("ab_rem", remaining, 4);
        tick();
        chk("ab_flush", fifo_flush, 1);
        chk("ab_rem_hold", remaining, 4);
        chk("ab_underrun", underrun, 0);
        abort = 0; start = 1; len = 16'd2;
        tick();
        start = 0;
        chk("ab_idle", busy, 0);
        chk("ab_rem_zero", remaining, 0);
        tick();
        chk("ab_start_ignored", busy, 0);
        chk("ab_flush_cnt", flush_cnt, 1);
        chk("ab_pops", pop_cnt, 2);
        chk("ab_done_cnt", done_cnt, 0);
        chk("ab_fifo_flushed", fq.size(), 0);
        chk("ab_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a packet: immediate IDLE, no flush
        clear_counts();
        tx_accept = 0;
        load(8'h30, 3);
        start = 1; len = 16'd3;
        tick();
        start = 0;
        tick();
        chk("rs_sending", tx_valid, 1);
        rst_n = 0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_rem", remaining, 0);
        chk("rs_valid", tx_valid, 0);
        chk("rs_flush", fifo_flush, 0);
        tick();
        rst_n = 1;
        fq.delete();
        refresh();
        tick();
        chk("rs_flush_cnt", flush_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
